// File: rtl/axil_cmd_sequencer.sv
// AXI4-Lite command sequencer: replays stored WRITE/WAIT/POLL/END slots
// as a standalone bus master, with abort and error reporting.
module axil_cmd_sequencer #(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int DEPTH      = 32,
    parameter  int N_EVT      = 2,
    parameter  int GAP_CYCLES = 1,
    parameter  int POLL_MAX   = 1024,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = 7 + ADDR_W + DATA_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_we,
    input  logic [PW-1:0]     cfg_idx,
    input  logic [CW-1:0]     cfg_cmd,
    input  logic              start,
    input  logic              abort,
    input  logic [N_EVT-1:0]  evt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [PW-1:0]     pc,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int CNTW = $clog2(POLL_MAX + 1);
    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GLST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_WAIT = 2'd1;
    localparam logic [1:0] OP_POLL = 2'd2;
    localparam logic [1:0] OP_END  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR_REQ, S_WR_RESP,
        S_RD_REQ, S_RD_DATA, S_WAIT, S_GAP
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]     mem [DEPTH];
    logic [CW-1:0]     slot;
    logic [1:0]        slot_op;
    logic [4:0]        slot_sel;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_data;

    logic [4:0]      sel_q;
    logic            abort_q;
    logic            inc_pc;
    logic [CNTW-1:0] pcnt;
    logic [GW-1:0]   gcnt;

    logic       abort_any, last, evt_hit, rbit;
    logic       fin, adv, retry, ld_wr, ld_rd, step;
    logic [2:0] ecode;

    assign slot      = mem[pc];
    assign slot_op   = slot[CW-1 -: 2];
    assign slot_sel  = slot[CW-3 -: 5];
    assign slot_addr = slot[DATA_W +: ADDR_W];
    assign slot_data = slot[DATA_W-1:0];

    assign abort_any = abort | abort_q;
    assign last      = (pc == PW'(DEPTH - 1));
    assign evt_hit   = |(32'(evt) & (32'd1 << sel_q));
    assign rbit      = |(m_axi_rdata & (DATA_W'(1) << sel_q));

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = '1;
    assign m_axi_bready = (state == S_WR_RESP);
    assign m_axi_rready = (state == S_RD_DATA);

    // Slot memory is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (cfg_we && !busy)
            mem[cfg_idx] <= cfg_cmd;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        fin     = 1'b0;
        ecode   = 3'd0;
        adv     = 1'b0;
        retry   = 1'b0;
        ld_wr   = 1'b0;
        ld_rd   = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_n = S_FETCH;
            S_FETCH: begin
                if (slot_op == OP_WAIT && 32'(slot_sel) >= N_EVT) begin
                    fin = 1'b1; ecode = 3'd3;
                end else if (abort_any) begin
                    fin = 1'b1; ecode = 3'd4;
                end else begin
                    case (slot_op)
                        OP_WR:   begin state_n = S_WR_REQ; ld_wr = 1'b1; end
                        OP_WAIT: state_n = S_WAIT;
                        OP_POLL: begin state_n = S_RD_REQ; ld_rd = 1'b1; end
                        OP_END:  fin = 1'b1;
                    endcase
                end
            end
            S_WR_REQ: begin
                if ((!m_axi_awvalid || m_axi_awready) &&
                    (!m_axi_wvalid || m_axi_wready))
                    state_n = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        fin = 1'b1; ecode = 3'd1;
                    end else if (abort_any) begin
                        fin = 1'b1; ecode = 3'd4;
                    end else if (last) begin
                        fin = 1'b1;
                    end else begin
                        adv = 1'b1;
                        state_n = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                    end
                end
            end
            S_RD_REQ: if (m_axi_arready) state_n = S_RD_DATA;
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        fin = 1'b1; ecode = 3'd1;
                    end else if (!rbit && pcnt == CNTW'(POLL_MAX - 1)) begin
                        fin = 1'b1; ecode = 3'd2;
                    end else if (abort_any) begin
                        fin = 1'b1; ecode = 3'd4;
                    end else if (!rbit) begin
                        retry = 1'b1;
                        state_n = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                    end else if (last) begin
                        fin = 1'b1;
                    end else begin
                        adv = 1'b1;
                        state_n = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                    end
                end
            end
            S_WAIT: begin
                if (abort_any) begin
                    fin = 1'b1; ecode = 3'd4;
                end else if (evt_hit) begin
                    if (last) begin
                        fin = 1'b1;
                    end else begin
                        adv = 1'b1;
                        state_n = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort_any) begin
                    fin = 1'b1; ecode = 3'd4;
                end else if (gcnt == GW'(GLST)) begin
                    state_n = S_FETCH;
                end
            end
        endcase
        if (fin) state_n = S_IDLE;
        // A poll retry revisits the same slot; only completed slots advance.
        step = (adv && state_n == S_FETCH) ||
               (state == S_GAP && state_n == S_FETCH && inc_pc);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 3'd0;
            pc            <= '0;
            abort_q       <= 1'b0;
            inc_pc        <= 1'b0;
            pcnt          <= '0;
            gcnt          <= '0;
            sel_q         <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_araddr  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= 3'd0;
                pc       <= '0;
                abort_q  <= 1'b0;
                pcnt     <= '0;
            end else if (busy && abort) begin
                abort_q <= 1'b1;
            end
            if (state == S_FETCH) sel_q <= slot_sel;
            if (ld_wr) begin
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                m_axi_awaddr  <= slot_addr;
                m_axi_wdata   <= slot_data;
            end else begin
                if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            end
            if (ld_rd) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= slot_addr;
            end else if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
            end
            gcnt <= (state == S_GAP) ? gcnt + 1'b1 : '0;
            if (adv || retry) inc_pc <= adv;
            if (adv)        pcnt <= '0;
            else if (retry) pcnt <= pcnt + 1'b1;
            if (step) pc <= pc + 1'b1;
            if (fin) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                error    <= (ecode != 3'd0);
                err_code <= ecode;
            end
        end
    end

endmodule

// File: doc/axil_cmd_sequencer.md
# axil_cmd_sequencer

Programmable AXI4-Lite master that replays a stored list of register commands (writes, event waits, bit polls) into the design's AXI4-Lite register space, e.g. SHA-256 message/control registers and scanner configuration registers. Sits beside the interconnect as an additional master, so hardware configures and sequences accelerators without a processor or VIP master. Generalises fixed write sequences with parametrised depth, widths, event channels, polling with timeout, and error reporting.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (wstrb all ones, width DATA_W/8)
- DEPTH, 32, command slots (power of 2, ≥2); PW = log2(DEPTH)
- N_EVT, 2, external event inputs (1..32)
- GAP_CYCLES, 1, idle cycles inserted after every completed command (0 allowed)
- POLL_MAX, 1024, max reads per POLL before timeout (≥1)
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- cfg_we  in  1  write command slot (ignored while busy)
- cfg_idx  in  PW  slot index
- cfg_cmd  in  2+5+ADDR_W+DATA_W  {op[1:0], sel[4:0], addr, data}
- start  in  1  begin execution at slot 0 (ignored while busy)
- abort  in  1  stop after current AXI transaction completes
- evt  in  N_EVT  level event inputs (e.g. digest_valid, scan done)
- busy, done, error  out  1  status; done/error sticky until next accepted start
- err_code  out  3  0 none, 1 bad resp, 2 poll timeout, 3 bad sel, 4 aborted
- pc  out  PW  slot currently/last executed
- m_axi_aw*/w*/b*/ar*/r*  standard AXI4-Lite master channels; awprot=arprot=3'b000

## Operation
- Ops: 0 WRITE addr←data; 1 WAIT until evt[sel]==1; 2 POLL read addr until rdata[sel]==1; 3 END.
- FSM: IDLE → FETCH → {WR_REQ, RD_REQ, WAIT_EVT, finish} → … → GAP → FETCH (pc+1).
- FETCH: registered slot read, 1 cycle; pc holds current slot.
- WR_REQ: awvalid and wvalid raised together; each dropped independently the cycle after its own handshake; leave when both done → WR_RESP (bready=1) until bvalid. bresp≠OKAY → error 1.
- RD_REQ: arvalid until arready → RD_DATA (rready=1) until rvalid. rresp≠OKAY → error 1. Bit set → GAP; else count++, count==POLL_MAX → error 2, else GAP then reissue the same read (pc unchanged).
- WAIT: sel≥N_EVT → error 3 immediately; else hold until evt[sel]==1 (already high counts, level not edge).
- END, or pc==DEPTH-1 completing without END: busy=0, done=1, error=0. No wrap.
- Error: busy=0, done=1, error=1, err_code set, pc frozen at faulting slot; no further AXI requests.
- abort: sampled any busy cycle, latched; in WAIT/GAP/FETCH stop next cycle; in AXI states finish outstanding handshake and response first; then error 4. Abort same cycle as error: error code of the fault wins.
- start and abort together in IDLE: start accepted, abort ignored.
- cfg_we during busy: no effect on memory.

## Timing
- Reset values: all valid/ready outputs 0, busy 0, done 0, error 0, err_code 0, pc 0, counters 0; command memory contents undefined (not reset).
- start accepted at edge N → busy=1 at N+1, FETCH at N+1, first awvalid/arvalid at N+2.
- WRITE with zero-wait slave: aw/w handshake at N+2, bvalid at N+3, next FETCH at N+4+GAP_CYCLES.
- Valid signals never drop before handshake; addr/data stable while valid.
- done/error assert the cycle after the final response or END fetch.
- aresetn low mid-transaction: all outputs to reset values next edge, outstanding transaction abandoned.

## Test plan
- Load 16 WRITEs to 0x44B0_0014..0x44B0_0050 (0x6162_6380, zeros, 0x18), then 0x44B0_0004←5, ←4, END → 18 AW in order with exact addr/data, done=1, error=0, pc=18.
- WAIT sel=0 then WRITE 0x44A0_0008←1039; raise evt[0] 50 cycles later → no AW before evt, AW 1+GAP_CYCLES+1 cycles after evt.
- POLL sel=0 at 0x44A0_0010, slave returns 0,0,0,1 → exactly 4 AR, then proceed; POLL_MAX=4 with always 0 → 4 reads, err_code=2.
- Second WRITE gets bresp=SLVERR → err_code=1, pc=1, no further AW.
- awready delayed 5 cycles, wready immediate; assert abort in cycle 2 → wvalid drops after W handshake, awvalid held stable, B consumed, err_code=4, no new request.
- WAIT sel=5 with N_EVT=2 → err_code=3; aresetn low during RD_DATA → all outputs reset next edge; new start runs from slot 0.
